// File: rtl/feeder_dispense_controller_if.sv
// feeder_dispense_controller_if: register-file read/write port used by the feeder controller
interface feeder_dispense_controller_if;
    logic [4:0]  ctrlReadReg;
    logic [31:0] readData;
    logic [4:0]  ctrlWriteReg;
    logic [31:0] writeData;
    logic        wren;

    modport master (
        output ctrlReadReg,
        input  readData,
        output ctrlWriteReg,
        output writeData,
        output wren
    );

    modport slave (
        input  ctrlReadReg,
        output readData,
        input  ctrlWriteReg,
        input  writeData,
        input  wren
    );
endinterface

// File: rtl/feeder_dispense_controller.sv
// feeder_dispense_controller: polls a command register, acknowledges it, and cycles the feeder servo once per portion (optional done pulse: FEEDER_DONE_PULSE_EN)
module feeder_dispense_controller #(
    parameter logic [4:0] CMD_REG      = 5'd3,
    parameter int         MAX_PORTIONS = 8,
    parameter int         PWM_PERIOD   = 1000000,
    parameter int         PULSE_OPEN   = 100000,
    parameter int         PULSE_CLOSED = 50000,
    parameter int         HOLD_PERIODS = 25
) (
    input  logic                         clock,
    input  logic                         reset_n,
    feeder_dispense_controller_if.master bus,
    output logic                         servo_pwm,
    output logic                         busy,
    output logic [3:0]                   portions_left,
    output logic                         done
);
    localparam int CW = $clog2(PWM_PERIOD);
    localparam int HW = $clog2(HOLD_PERIODS + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] W_OPEN     = CW'(PULSE_OPEN);
    localparam logic [CW-1:0] W_CLOSED   = CW'(PULSE_CLOSED);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_PERIODS - 1);
    localparam logic [3:0]    MAXP       = 4'(MAX_PORTIONS);

    typedef enum logic [2:0] {IDLE, ACK, SYNC, OPEN, CLOSE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    por_q, por_d;
    logic          pwm_q, pwm_d;
    logic          frame_end, hold_done;
    logic [3:0]    n;

    assign frame_end = cnt_q == FRAME_LAST;
    assign hold_done = frame_end && hold_q == HOLD_LAST;
    assign n         = bus.readData[3:0];

    // Next state, frame counter, and servo level; pwm uses the next counter and
    // next state so a position change always lands on a frame boundary.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        por_d   = por_q;
        cnt_d   = frame_end ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (n != 4'd0) begin
                    por_d   = n > MAXP ? MAXP : n;
                    state_d = ACK;
                end
            end
            ACK:  state_d = SYNC;
            SYNC: state_d = frame_end ? OPEN : SYNC;
            OPEN: begin
                if (frame_end) hold_d = hold_done ? '0 : hold_q + 1'b1;
                if (hold_done) state_d = CLOSE;
            end
            CLOSE: begin
                if (frame_end) hold_d = hold_done ? '0 : hold_q + 1'b1;
                if (hold_done) begin
                    por_d   = por_q > 4'd1 ? por_q - 1'b1 : 4'd0;
                    state_d = por_q > 4'd1 ? OPEN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pwm_d = cnt_d < (state_d == OPEN ? W_OPEN : W_CLOSED);
    end

    // State and datapath registers; reset aborts any job and drops the servo line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            por_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            por_q   <= por_d;
            pwm_q   <= pwm_d;
        end
    end

`ifdef FEEDER_DONE_PULSE_EN
    logic done_q;

    // One-cycle pulse raised together with the return to IDLE after the last portion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) done_q <= 1'b0;
        else          done_q <= state_q == CLOSE && state_d == IDLE;
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    assign bus.ctrlReadReg  = CMD_REG;
    assign bus.ctrlWriteReg = CMD_REG;
    assign bus.writeData    = 32'd0;
    assign bus.wren         = state_q == ACK;
    assign servo_pwm        = pwm_q;
    assign busy             = state_q != IDLE;
    assign portions_left    = por_q;
endmodule

// File: doc/feeder_dispense_controller.md
Name: feeder_dispense_controller

Overview:
Hardware reader/actuator for the CPU register file. It polls a command register that software fills with a portion count, then acknowledges by writing 0 back to that register. It then drives the feeder servo through open/close cycles, one per portion. It sits beside the button controller on a dedicated register-file read port and write port.

Parameters:
CMD_REG, 5'd3, register index polled for commands and cleared on acceptance
MAX_PORTIONS, 8, clamp for the requested portion count (1..15)
PWM_PERIOD, 1000000, servo frame length in clock cycles (20 ms at 50 MHz)
PULSE_OPEN, 100000, high time per frame for the open position (2 ms)
PULSE_CLOSED, 50000, high time per frame for the closed position (1 ms)
HOLD_PERIODS, 25, frames held in each position per phase

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
ctrlReadReg  out  5  register-file read index, constant CMD_REG
readData  in  32  register-file read data for ctrlReadReg
ctrlWriteReg  out  5  register-file write index, constant CMD_REG
writeData  out  32  write data, always 32'd0
wren  out  1  write enable, single-cycle acknowledge pulse
servo_pwm  out  1  servo control signal
busy  out  1  high in every state except IDLE
portions_left  out  4  remaining portions including the one in progress
done  out  1  completion pulse (see Optional Feature)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; frame counter=0; hold counter=0; portions_left=0.
  - wren=0, servo_pwm=0, busy=0, done=0.
- Frame counter:
  - Free-runs 0..PWM_PERIOD-1 and wraps to 0.
  - servo_pwm is registered: high when counter < pulse width. Width = PULSE_OPEN in OPEN, PULSE_CLOSED in all other states, so the idle servo is held closed.
  - frame_end = (counter == PWM_PERIOD-1).
- Command decode: n = readData[3:0]. n=0 means no command. n>MAX_PORTIONS is clamped to MAX_PORTIONS. readData[31:4] is ignored.
- States:
  - IDLE: if n!=0 at edge T, latch clamped n into portions_left and go to ACK.
  - ACK: exactly one cycle (T+1) with wren=1, writeData=0, ctrlWriteReg=CMD_REG; then go to SYNC.
  - SYNC: readData is ignored. On frame_end go to OPEN, so OPEN starts at counter=0.
  - OPEN: count HOLD_PERIODS frame_ends, then go to CLOSE; reset the hold counter.
  - CLOSE: count HOLD_PERIODS frame_ends.
    - If portions_left>1: decrement and go to OPEN.
    - If portions_left==1: set it to 0 and go to IDLE.
- Every servo position change is aligned to a frame boundary; no runt pulses.
- wren is asserted only in ACK, exactly once per accepted command.
- Commands written by software while busy: not read and not cleared. They remain in the register and are accepted in IDLE after the current job finishes.
- Reset mid-operation aborts the job. The command register is not rewritten (it was already cleared at ACK), and servo_pwm returns low immediately.
- Widths: the frame counter is sized $clog2(PWM_PERIOD); the hold counter is sized $clog2(HOLD_PERIODS+1).

Optional Feature:
Macro FEEDER_DONE_PULSE_EN.
- Defined: done=1 for exactly one cycle, the cycle in which CLOSE transitions to IDLE (last portion complete).
- Undefined: done is tied to 0 and no completion logic is synthesized. All other behaviour is identical.

Test Plan (bench params: PWM_PERIOD=20, PULSE_OPEN=4, PULSE_CLOSED=2, HOLD_PERIODS=2, MAX_PORTIONS=8):
- readData=3 sampled at T:
  - wren=1 with writeData=0 and ctrlWriteReg=3 at T+1 only.
  - busy rises at T+1; portions_left=3.
  - Three cycles of 2 open frames (4-cycle pulses) then 2 closed frames (2-cycle pulses).
  - portions_left steps 3->2->1->0; busy falls after the last CLOSE.
- Idle with readData=0 for 100 cycles -> wren never asserted; servo_pwm is high 2 of every 20 cycles.
- readData=32'h0000_00FD (n=13) -> portions_left=8 and exactly 8 open phases.
- Software writes 2 while a 1-portion job is in OPEN:
  - No wren until that job ends.
  - Then the new command is accepted; a second ACK follows within 1 cycle of re-entering IDLE.
- reset_n pulled low mid-OPEN -> servo_pwm, busy and wren are 0 asynchronously; after release, IDLE with a fresh frame from counter=0.
- With FEEDER_DONE_PULSE_EN, a 1-portion job gives one 1-cycle done pulse coincident with busy falling. Without the macro, done stays 0 throughout.
